// File: rtl/decode_stage.sv
// RV32I instruction decode stage: IF/ID register, field/immediate decode,
// 32x32 register file with write-back bypass, and a registered ID/EX bundle.
module decode_stage #(
    parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] if_pc_i,
    input  logic [31:0] if_instr_i,
    input  logic        stall_i,
    input  logic        flush_i,
    input  logic        wb_we_i,
    input  logic [4:0]  wb_rd_i,
    input  logic [31:0] wb_data_i,
    output logic        id_valid_o,
    output logic [31:0] id_pc_o,
    output logic [6:0]  id_opcode_o,
    output logic [2:0]  id_funct3_o,
    output logic        id_funct7b5_o,
    output logic [4:0]  id_rs1_o,
    output logic [4:0]  id_rs2_o,
    output logic [4:0]  id_rd_o,
    output logic [31:0] id_rs1_data_o,
    output logic [31:0] id_rs2_data_o,
    output logic [31:0] id_imm_o,
    output logic        id_illegal_o
);

    function automatic logic signed [31:0] sext12(input logic [11:0] v);
        return {{20{v[11]}}, v};
    endfunction

    function automatic logic signed [31:0] sext13(input logic [12:0] v);
        return {{19{v[12]}}, v};
    endfunction

    function automatic logic signed [31:0] sext21(input logic [20:0] v);
        return {{11{v[20]}}, v};
    endfunction

    // ---- IF/ID register (stage p0) ----
    logic [31:0] pc_p0_q, pc_p0_d;
    logic [31:0] instr_p0_q, instr_p0_d;
    logic        vld_p0_q, vld_p0_d;

    always_comb begin
        pc_p0_d    = pc_p0_q;
        instr_p0_d = instr_p0_q;
        vld_p0_d   = vld_p0_q;
        if (rst || flush_i) begin
            pc_p0_d    = '0;
            instr_p0_d = NOP_INSTR;
            vld_p0_d   = 1'b0;
        end else if (!stall_i) begin
            pc_p0_d    = if_pc_i;
            instr_p0_d = if_instr_i;
            vld_p0_d   = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        pc_p0_q    <= pc_p0_d;
        instr_p0_q <= instr_p0_d;
        vld_p0_q   <= vld_p0_d;
    end

    // ---- Decode and operand read (combinational from p0) ----
    logic [6:0]         opcode_p0;
    logic [4:0]         rs1_p0, rs2_p0, rd_p0;
    logic signed [31:0] imm_p0;
    logic               illegal_p0;
    logic [31:0]        rs1_data_p0, rs2_data_p0;

    assign opcode_p0 = instr_p0_q[6:0];
    assign rd_p0     = instr_p0_q[11:7];
    assign rs1_p0    = instr_p0_q[19:15];
    assign rs2_p0    = instr_p0_q[24:20];

    always_comb begin
        imm_p0     = '0;
        illegal_p0 = 1'b0;
        if (instr_p0_q[1:0] != 2'b11) begin
            illegal_p0 = 1'b1;
        end else begin
            case (opcode_p0)
                7'b0010011, 7'b0000011, 7'b1100111, 7'b1110011, 7'b0001111:
                    imm_p0 = sext12(instr_p0_q[31:20]);
                7'b0100011:
                    imm_p0 = sext12({instr_p0_q[31:25], instr_p0_q[11:7]});
                7'b1100011:
                    imm_p0 = sext13({instr_p0_q[31], instr_p0_q[7], instr_p0_q[30:25],
                                     instr_p0_q[11:8], 1'b0});
                7'b0110111, 7'b0010111:
                    imm_p0 = {instr_p0_q[31:12], 12'b0};
                7'b1101111:
                    imm_p0 = sext21({instr_p0_q[31], instr_p0_q[19:12], instr_p0_q[20],
                                     instr_p0_q[30:21], 1'b0});
                7'b0110011:
                    imm_p0 = '0;
                default:
                    illegal_p0 = 1'b1;
            endcase
        end
    end

    logic [31:0] rf_q [32];
    logic        wb_wr;

    // x0 is never written, so its entry stays at its reset value of zero
    assign wb_wr = wb_we_i && (wb_rd_i != 5'd0);

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 32; i++) rf_q[i] <= '0;
        end else if (wb_wr) begin
            rf_q[wb_rd_i] <= wb_data_i;
        end
    end

    always_comb begin
        rs1_data_p0 = '0;
        rs2_data_p0 = '0;
        if (rs1_p0 != 5'd0) rs1_data_p0 = (wb_wr && wb_rd_i == rs1_p0) ? wb_data_i : rf_q[rs1_p0];
        if (rs2_p0 != 5'd0) rs2_data_p0 = (wb_wr && wb_rd_i == rs2_p0) ? wb_data_i : rf_q[rs2_p0];
    end

    // ---- ID/EX register (stage p1) ----
    logic               vld_p1_q, vld_p1_d;
    logic [31:0]        pc_p1_q, pc_p1_d;
    logic [6:0]         opcode_p1_q, opcode_p1_d;
    logic [2:0]         funct3_p1_q, funct3_p1_d;
    logic               f7b5_p1_q, f7b5_p1_d;
    logic [4:0]         rs1_p1_q, rs1_p1_d, rs2_p1_q, rs2_p1_d, rd_p1_q, rd_p1_d;
    logic [31:0]        rs1_data_p1_q, rs1_data_p1_d, rs2_data_p1_q, rs2_data_p1_d;
    logic signed [31:0] imm_p1_q, imm_p1_d;
    logic               illegal_p1_q, illegal_p1_d;

    // A stall bubbles ID/EX exactly like a flush; IF/ID holds so the instruction re-decodes
    always_comb begin
        vld_p1_d      = 1'b0;
        pc_p1_d       = '0;
        opcode_p1_d   = '0;
        funct3_p1_d   = '0;
        f7b5_p1_d     = 1'b0;
        rs1_p1_d      = '0;
        rs2_p1_d      = '0;
        rd_p1_d       = '0;
        rs1_data_p1_d = '0;
        rs2_data_p1_d = '0;
        imm_p1_d      = '0;
        illegal_p1_d  = 1'b0;
        if (!(rst || flush_i || stall_i)) begin
            vld_p1_d      = vld_p0_q;
            pc_p1_d       = pc_p0_q;
            opcode_p1_d   = opcode_p0;
            funct3_p1_d   = instr_p0_q[14:12];
            f7b5_p1_d     = instr_p0_q[30];
            rs1_p1_d      = rs1_p0;
            rs2_p1_d      = rs2_p0;
            rd_p1_d       = rd_p0;
            rs1_data_p1_d = rs1_data_p0;
            rs2_data_p1_d = rs2_data_p0;
            imm_p1_d      = imm_p0;
            illegal_p1_d  = illegal_p0;
        end
    end

    always_ff @(posedge clk) begin
        vld_p1_q      <= vld_p1_d;
        pc_p1_q       <= pc_p1_d;
        opcode_p1_q   <= opcode_p1_d;
        funct3_p1_q   <= funct3_p1_d;
        f7b5_p1_q     <= f7b5_p1_d;
        rs1_p1_q      <= rs1_p1_d;
        rs2_p1_q      <= rs2_p1_d;
        rd_p1_q       <= rd_p1_d;
        rs1_data_p1_q <= rs1_data_p1_d;
        rs2_data_p1_q <= rs2_data_p1_d;
        imm_p1_q      <= imm_p1_d;
        illegal_p1_q  <= illegal_p1_d;
    end

    assign id_valid_o    = vld_p1_q;
    assign id_pc_o       = pc_p1_q;
    assign id_opcode_o   = opcode_p1_q;
    assign id_funct3_o   = funct3_p1_q;
    assign id_funct7b5_o = f7b5_p1_q;
    assign id_rs1_o      = rs1_p1_q;
    assign id_rs2_o      = rs2_p1_q;
    assign id_rd_o       = rd_p1_q;
    assign id_rs1_data_o = rs1_data_p1_q;
    assign id_rs2_data_o = rs2_data_p1_q;
    assign id_imm_o      = imm_p1_q;
    assign id_illegal_o  = illegal_p1_q;

endmodule

// File: tb/tb_decode_stage.sv
// Scoreboard bench for decode_stage: directed and random stimulus against an
// instruction-level reference model; a monitor compares every output cycle.
module tb_decode_stage;

    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] if_pc_i, if_instr_i;
    logic        stall_i, flush_i, wb_we_i;
    logic [4:0]  wb_rd_i;
    logic [31:0] wb_data_i;
    logic        id_valid_o, id_funct7b5_o, id_illegal_o;
    logic [31:0] id_pc_o, id_rs1_data_o, id_rs2_data_o, id_imm_o;
    logic [6:0]  id_opcode_o;
    logic [2:0]  id_funct3_o;
    logic [4:0]  id_rs1_o, id_rs2_o, id_rd_o;

    decode_stage #(.NOP_INSTR(NOP)) dut (
        .clk(clk), .rst(rst), .if_pc_i(if_pc_i), .if_instr_i(if_instr_i),
        .stall_i(stall_i), .flush_i(flush_i), .wb_we_i(wb_we_i), .wb_rd_i(wb_rd_i),
        .wb_data_i(wb_data_i), .id_valid_o(id_valid_o), .id_pc_o(id_pc_o),
        .id_opcode_o(id_opcode_o), .id_funct3_o(id_funct3_o), .id_funct7b5_o(id_funct7b5_o),
        .id_rs1_o(id_rs1_o), .id_rs2_o(id_rs2_o), .id_rd_o(id_rd_o),
        .id_rs1_data_o(id_rs1_data_o), .id_rs2_data_o(id_rs2_data_o),
        .id_imm_o(id_imm_o), .id_illegal_o(id_illegal_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        vld;
        logic [31:0] pc;
        logic [6:0]  op;
        logic [2:0]  f3;
        logic        f7;
        logic [4:0]  rs1, rs2, rd;
        logic [31:0] d1, d2, imm;
        logic        ill;
        int          id;
    } exp_t;

    exp_t        sb[$];
    int          total = 0;
    int          bad = 0;
    int          cyc = 0;

    // Reference state: the instruction waiting in decode, and architectural registers
    logic [31:0] m_pc, m_instr;
    logic        m_vld;
    logic [31:0] m_rf [32];

    logic [6:0]  ops [11] = '{7'h13, 7'h03, 7'h67, 7'h73, 7'h0F, 7'h23,
                              7'h63, 7'h37, 7'h17, 7'h6F, 7'h33};

    function automatic exp_t zero_bundle();
        exp_t e;
        e.vld = 0; e.pc = 0; e.op = 0; e.f3 = 0; e.f7 = 0;
        e.rs1 = 0; e.rs2 = 0; e.rd = 0; e.d1 = 0; e.d2 = 0; e.imm = 0; e.ill = 0; e.id = 0;
        return e;
    endfunction

    function automatic exp_t ref_decode(input logic [31:0] ins, input logic [31:0] pc, input logic v);
        exp_t e;
        int   imm;
        e = zero_bundle();
        e.vld = v; e.pc = pc; e.op = ins[6:0]; e.f3 = ins[14:12]; e.f7 = ins[30];
        e.rd = ins[11:7]; e.rs1 = ins[19:15]; e.rs2 = ins[24:20];
        imm = 0;
        e.ill = 0;
        case (ins[6:0])
            7'h13, 7'h03, 7'h67, 7'h73, 7'h0F: imm = int'($signed(ins[31:20]));
            7'h23: imm = int'($signed({ins[31:25], ins[11:7]}));
            7'h63: imm = int'($signed({ins[31], ins[7], ins[30:25], ins[11:8]})) * 2;
            7'h37, 7'h17: imm = int'(ins[31:12]) * 4096;
            7'h6F: imm = int'($signed({ins[31], ins[19:12], ins[20], ins[30:21]})) * 2;
            7'h33: imm = 0;
            default: e.ill = 1;
        endcase
        if (ins[1:0] != 2'b11) e.ill = 1;
        e.imm = e.ill ? 32'h0 : imm;
        return e;
    endfunction

    function automatic logic [31:0] ref_read(input logic [4:0] idx, input logic we,
                                             input logic [4:0] rd, input logic [31:0] wd);
        if (idx == 0) return 32'h0;
        if (we && rd == idx) return wd;
        return m_rf[idx];
    endfunction

    task automatic step(input logic r, input logic [31:0] pc, input logic [31:0] ins,
                        input logic st, input logic fl, input logic we,
                        input logic [4:0] rd, input logic [31:0] wd);
        exp_t e;
        @(negedge clk);
        rst = r; if_pc_i = pc; if_instr_i = ins; stall_i = st; flush_i = fl;
        wb_we_i = we; wb_rd_i = rd; wb_data_i = wd;
        if (r || fl || st) begin
            e = zero_bundle();
        end else begin
            e = ref_decode(m_instr, m_pc, m_vld);
            e.d1 = ref_read(e.rs1, we, rd, wd);
            e.d2 = ref_read(e.rs2, we, rd, wd);
        end
        e.id = cyc;
        sb.push_back(e);
        if (r) begin
            for (int i = 0; i < 32; i++) m_rf[i] = 0;
        end else if (we && rd != 0) begin
            m_rf[rd] = wd;
        end
        if (r || fl) begin
            m_pc = 0; m_instr = NOP; m_vld = 0;
        end else if (!st) begin
            m_pc = pc; m_instr = ins; m_vld = 1;
        end
        cyc++;
    endtask

    task automatic run(input logic [31:0] pc, input logic [31:0] ins);
        step(0, pc, ins, 0, 0, 0, 0, 0);
    endtask

    // Monitor: one bundle is due after every edge that follows a pushed stimulus
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (sb.size() > 0) begin
                e = sb.pop_front();
                total++;
                if (id_valid_o !== e.vld || id_pc_o !== e.pc || id_opcode_o !== e.op ||
                    id_funct3_o !== e.f3 || id_funct7b5_o !== e.f7 || id_rs1_o !== e.rs1 ||
                    id_rs2_o !== e.rs2 || id_rd_o !== e.rd || id_rs1_data_o !== e.d1 ||
                    id_rs2_data_o !== e.d2 || id_imm_o !== e.imm || id_illegal_o !== e.ill) begin
                    bad++;
                    $display("FAIL bundle cyc=%0d got/want: vld %b/%b pc %h/%h op %h/%h f3 %0d/%0d f7 %b/%b rs %0d,%0d,%0d/%0d,%0d,%0d d1 %h/%h d2 %h/%h imm %h/%h ill %b/%b",
                             e.id, id_valid_o, e.vld, id_pc_o, e.pc, id_opcode_o, e.op,
                             id_funct3_o, e.f3, id_funct7b5_o, e.f7, id_rs1_o, id_rs2_o, id_rd_o,
                             e.rs1, e.rs2, e.rd, id_rs1_data_o, e.d1, id_rs2_data_o, e.d2,
                             id_imm_o, e.imm, id_illegal_o, e.ill);
                end
            end
        end
    end

    initial begin
        logic [31:0] ins;
        rst = 1; if_pc_i = 0; if_instr_i = 0; stall_i = 0; flush_i = 0;
        wb_we_i = 0; wb_rd_i = 0; wb_data_i = 0;
        m_pc = 0; m_instr = NOP; m_vld = 0;
        for (int i = 0; i < 32; i++) m_rf[i] = 0;

        // Reset with random inputs on every other port
        repeat (2) step(1, $urandom, $urandom, 1'($urandom), 1'($urandom), 1'($urandom),
                        5'($urandom), $urandom);
        // Freshly reset registers all read zero
        for (int i = 0; i < 4; i++) begin
            ins = $urandom; ins[6:0] = 7'h33;
            run(32'h200 + 32'(i * 4), ins);
        end

        // Immediate forms
        run(32'd0,  32'hFFF00093);
        run(32'd4,  32'h0020A423);
        run(32'd8,  32'hFE208EE3);
        run(32'd12, 32'h123452B7);
        run(32'd16, 32'h001000EF);
        run(32'd20, NOP);

        // Same-cycle bypass of x3, then a plain read of x3 and an ignored x0 write
        run(32'h40, 32'h00018233);
        step(0, 32'h44, 32'h00100313, 0, 0, 1, 5'd3, 32'hDEADBEEF);
        step(0, 32'h48, 32'h003183B3, 0, 0, 1, 5'd0, 32'h5);
        run(32'h4C, 32'h00000333);
        run(32'h50, NOP);

        // Two-cycle stall: fetch words during the stall never appear
        run(32'h100, 32'h00318233);
        run(32'h104, 32'h00418293);
        step(0, 32'hBAD0, 32'hFFF00093, 1, 0, 0, 0, 0);
        step(0, 32'hBAD4, 32'h123452B7, 1, 0, 0, 0, 0);
        run(32'h108, 32'h0020A423);
        run(32'h10C, NOP);

        // Flush and stall together
        run(32'h300, 32'h00318233);
        step(0, 32'h304, 32'h00418293, 1, 1, 0, 0, 0);
        run(32'h308, 32'hFE208EE3);
        run(32'h30C, NOP);
        run(32'h310, NOP);

        // Illegal encodings
        run(32'h400, 32'h00000000);
        run(32'h404, 32'hFFFFFFFF);
        run(32'h408, NOP);
        run(32'h40C, NOP);

        // Random traffic with occasional stall, flush, mid-stream reset and write-back
        for (int i = 0; i < 400; i++) begin
            ins = $urandom;
            if ($urandom_range(0, 7) != 0) ins[6:0] = ops[$urandom_range(0, 10)];
            step($urandom_range(0, 99) == 0, $urandom, ins,
                 $urandom_range(0, 7) == 0, $urandom_range(0, 15) == 0,
                 1'($urandom), 5'($urandom), $urandom);
        end
        repeat (3) run(32'h0, NOP);

        repeat (4) @(posedge clk);
        #2;
        if (sb.size() != 0) begin
            bad++;
            $display("FAIL drain pending=%0d required=0", sb.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
